// File: rtl/exposure_trig_sched.sv
// Exposure trigger scheduler: free-run / external / software triggered frames with delay, fixed pulse and minimum period.
// IDLE wait for request | DELAY count trigger delay | PULSE trigger_out high | WAIT fill remaining frame period
module exposure_trig_sched #(
    parameter int unsigned TRIG_PULSE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  reg_trig_mode,
    input  logic [31:0] reg_frame_period,
    input  logic [31:0] reg_trig_delay,
    input  logic [31:0] reg_exposure_time,
    input  logic [1:0]  reg_chan_mask,
    input  logic        reg_cnt_clr,
    input  logic        ext_trig_in,
    input  logic        soft_trig,
    output logic        trigger_out,
    output logic [1:0]  exp_chan,
    output logic [31:0] exp_time_out,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, WAIT} state_t;

    localparam logic [31:0] MIN_PERIOD_M1 = 32'(TRIG_PULSE_W);
    localparam logic [7:0]  PULSE_LAST    = 8'(TRIG_PULSE_W - 1);

    state_t      state;
    logic        ext_s1, ext_s2, ext_s3, ext_req;
    logic        alt_next;
    logic [31:0] dly_cnt, per_cnt, per_last, lat_exp;
    logic [7:0]  pulse_cnt;
    logic        lat_chan;

    logic        mode_free, mask_ok, hw_req, per_done;
    logic        latch_now, direct, pulse_entry;
    logic        new_chan, entry_chan;
    logic [31:0] new_per_last, entry_exp;

    assign mode_free    = (reg_trig_mode == 2'd1);
    assign mask_ok      = |reg_chan_mask;
    assign hw_req       = ((reg_trig_mode == 2'd2) && ext_req) || ((reg_trig_mode == 2'd3) && soft_trig);
    assign per_done     = (per_cnt == per_last);
    assign busy         = (state != IDLE);
    assign new_chan     = (reg_chan_mask == 2'b11) ? alt_next : reg_chan_mask[1];
    assign new_per_last = (reg_frame_period > MIN_PERIOD_M1) ? reg_frame_period - 32'd1 : MIN_PERIOD_M1;

    // A frame is latched from IDLE on any accepted request, or re-armed at the end of WAIT in free-run.
    assign latch_now   = mask_ok && (((state == IDLE) && (mode_free || hw_req)) ||
                                     ((state == WAIT) && per_done && mode_free));
    assign direct      = latch_now && (mode_free || (reg_trig_delay == 32'd0));
    assign pulse_entry = direct || ((state == DELAY) && (dly_cnt == 32'd0));
    assign entry_chan  = direct ? new_chan : lat_chan;
    assign entry_exp   = direct ? reg_exposure_time : lat_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_s1  <= 1'b0;
            ext_s2  <= 1'b0;
            ext_s3  <= 1'b0;
            ext_req <= 1'b0;
        end else begin
            ext_s1  <= ext_trig_in;
            ext_s2  <= ext_s1;
            ext_s3  <= ext_s2;
            ext_req <= ext_s2 & ~ext_s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            trigger_out  <= 1'b0;
            exp_chan     <= 2'd0;
            exp_time_out <= 32'd0;
            frame_cnt    <= 32'd0;
            alt_next     <= 1'b0;
            dly_cnt      <= 32'd0;
            per_cnt      <= 32'd0;
            per_last     <= 32'd0;
            lat_exp      <= 32'd0;
            lat_chan     <= 1'b0;
            pulse_cnt    <= 8'd0;
        end else begin
            if (latch_now) begin
                per_last <= new_per_last;
                lat_exp  <= reg_exposure_time;
                lat_chan <= new_chan;
                if (reg_chan_mask == 2'b11) begin
                    alt_next <= ~alt_next;
                end
            end
            if (pulse_entry) begin
                state        <= PULSE;
                trigger_out  <= 1'b1;
                pulse_cnt    <= 8'd0;
                per_cnt      <= 32'd0;
                frame_cnt    <= frame_cnt + 32'd1;
                exp_chan     <= {1'b0, entry_chan};
                exp_time_out <= entry_exp;
            end else begin
                case (state)
                    IDLE: begin
                        if (latch_now) begin
                            state   <= DELAY;
                            dly_cnt <= reg_trig_delay - 32'd1;
                        end
                    end
                    DELAY: dly_cnt <= dly_cnt - 32'd1;
                    PULSE: begin
                        per_cnt <= per_cnt + 32'd1;
                        if (pulse_cnt == PULSE_LAST) begin
                            trigger_out <= 1'b0;
                            state       <= WAIT;
                        end else begin
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end
                    end
                    WAIT: begin
                        if (per_done) begin
                            state <= IDLE;
                        end else begin
                            per_cnt <= per_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Clear has priority over a drop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (reg_cnt_clr) begin
            drop_cnt <= 16'd0;
        end else if (hw_req && busy && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_exposure_trig_sched.sv
// Bench for exposure_trig_sched: frame-level reference model feeds a scoreboard of expected frames;
// a monitor pops one entry per trigger_out rising edge and checks timing, channel, exposure and count.
module tb_exposure_trig_sched;

    localparam int W    = 8;
    localparam int MAXC = 20000;

    typedef struct {
        int          rise;
        int          chan;
        logic [31:0] expo;
        logic [31:0] frame;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  reg_trig_mode = 2'd0;
    logic [31:0] reg_frame_period = 32'd0;
    logic [31:0] reg_trig_delay = 32'd0;
    logic [31:0] reg_exposure_time = 32'd0;
    logic [1:0]  reg_chan_mask = 2'd0;
    logic        reg_cnt_clr = 1'b0;
    logic        ext_trig_in = 1'b0;
    logic        soft_trig = 1'b0;
    logic        trigger_out;
    logic [1:0]  exp_chan;
    logic [31:0] exp_time_out;
    logic        busy;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    exposure_trig_sched #(.TRIG_PULSE_W(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reg_trig_mode     (reg_trig_mode),
        .reg_frame_period  (reg_frame_period),
        .reg_trig_delay    (reg_trig_delay),
        .reg_exposure_time (reg_exposure_time),
        .reg_chan_mask     (reg_chan_mask),
        .reg_cnt_clr       (reg_cnt_clr),
        .ext_trig_in       (ext_trig_in),
        .soft_trig         (soft_trig),
        .trigger_out       (trigger_out),
        .exp_chan          (exp_chan),
        .exp_time_out      (exp_time_out),
        .busy              (busy),
        .frame_cnt         (frame_cnt),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    // Reference model: a frame occupies [accept+1, rise+spacing-1]; everything else is idle time.
    frame_t sb[$];
    int     idle_from = 0;
    int     alt       = 0;
    int     frames_m  = 0;
    int     drops_m   = 0;
    bit     lvl[MAXC];

    function automatic void launch(int r);
        frame_t f;
        int     spacing;
        spacing = (int'(reg_frame_period) > W + 1) ? int'(reg_frame_period) : W + 1;
        if (reg_chan_mask == 2'd1) f.chan = 0;
        else if (reg_chan_mask == 2'd2) f.chan = 1;
        else begin
            f.chan = alt;
            alt    = 1 - alt;
        end
        frames_m++;
        f.rise  = r;
        f.expo  = reg_exposure_time;
        f.frame = 32'(frames_m);
        sb.push_back(f);
        idle_from = r + spacing;
    endfunction

    function automatic void model_cycle(int k);
        bit ext_rq;
        bit req;
        ext_rq = (k >= 4) && lvl[k-3] && !lvl[k-4];
        if (reg_trig_mode == 2'd1) begin
            // free-run starts from idle, or back-to-back from the last cycle of the running frame
            if ((k >= idle_from - 1) && (reg_chan_mask != 2'd0)) launch(k + 1);
        end else begin
            req = ((reg_trig_mode == 2'd2) && ext_rq) || ((reg_trig_mode == 2'd3) && soft_trig);
            if (req) begin
                if (k < idle_from) begin
                    if (drops_m < 65535) drops_m++;
                end else if (reg_chan_mask != 2'd0) begin
                    launch(k + 1 + int'(reg_trig_delay));
                end
            end
        end
        if (reg_cnt_clr) drops_m = 0;
    endfunction

    task automatic tick();
        check("busy", longint'(busy), (cyc < idle_from) ? 1 : 0);
        check("drop_cnt", longint'(drop_cnt), drops_m);
        if (cyc < MAXC) lvl[cyc] = ext_trig_in;
        model_cycle(cyc);
        @(negedge clk);
        soft_trig   = 1'b0;
        reg_cnt_clr = 1'b0;
    endtask

    // Monitor: one scoreboard entry per trigger rise; outputs must hold between frames.
    logic        trig_prev = 1'b0;
    int          width = 0;
    int          cur_chan = 0;
    logic [31:0] cur_exp = 32'd0;
    logic [31:0] cur_frame = 32'd0;

    always @(negedge clk) begin
        frame_t f;
        if (!rst_n) begin
            trig_prev = 1'b0;
            width     = 0;
            cur_chan  = 0;
            cur_exp   = 32'd0;
            cur_frame = 32'd0;
        end else begin
            if (trigger_out && !trig_prev) begin
                check("frame_expected", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    f = sb.pop_front();
                    check("rise_cycle", cyc, f.rise);
                    cur_chan  = f.chan;
                    cur_exp   = f.expo;
                    cur_frame = f.frame;
                end
                width = 1;
            end else if (trigger_out) begin
                width++;
            end else if (trig_prev) begin
                check("pulse_width", width, W);
            end
            check("exp_chan", longint'(exp_chan), cur_chan);
            check("exp_time_out", longint'(exp_time_out), longint'(cur_exp));
            check("frame_cnt", longint'(frame_cnt), longint'(cur_frame));
            trig_prev = trigger_out;
        end
    end

    task automatic check_reset_values(string tag);
        check({tag, "_trigger_out"}, longint'(trigger_out), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_exp_chan"}, longint'(exp_chan), 0);
        check({tag, "_exp_time_out"}, longint'(exp_time_out), 0);
        check({tag, "_frame_cnt"}, longint'(frame_cnt), 0);
        check({tag, "_drop_cnt"}, longint'(drop_cnt), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // free-run, period 100, alternating channels
        reg_frame_period  = 32'd100;
        reg_chan_mask     = 2'd3;
        reg_exposure_time = 32'd1234;
        reg_trig_mode     = 2'd1;
        repeat (420) tick();
        reg_trig_mode = 2'd0;
        repeat (110) tick();

        // external edge with delay 10
        reg_trig_mode     = 2'd2;
        reg_trig_delay    = 32'd10;
        reg_frame_period  = 32'd20;
        reg_chan_mask     = 2'd2;
        reg_exposure_time = 32'd77;
        repeat (5) tick();
        ext_trig_in = 1'b1;
        repeat (6) tick();
        ext_trig_in = 1'b0;
        repeat (50) tick();

        // software triggers: one drop, then clear colliding with a drop
        reg_trig_mode    = 2'd3;
        reg_frame_period = 32'd50;
        reg_trig_delay   = 32'd0;
        reg_chan_mask    = 2'd1;
        soft_trig = 1'b1; tick();
        repeat (19) tick();
        soft_trig = 1'b1; tick();
        repeat (40) tick();
        soft_trig = 1'b1; tick();
        repeat (5) tick();
        soft_trig = 1'b1; reg_cnt_clr = 1'b1; tick();
        repeat (60) tick();

        // period below minimum spacing, then mode off mid-pulse
        reg_trig_mode    = 2'd1;
        reg_frame_period = 32'd3;
        repeat (30) tick();
        for (int t = 0; t < 20 && !trigger_out; t++) tick();
        check("pulse_seen_before_mode_off", longint'(trigger_out), 1);
        reg_trig_mode = 2'd0;
        repeat (30) tick();

        // randomized traffic, register changes mid-frame included
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) reg_trig_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 3) begin
                reg_trig_delay    = 32'($urandom_range(0, 15));
                reg_frame_period  = 32'($urandom_range(0, 40));
                reg_chan_mask     = 2'($urandom_range(0, 3));
                reg_exposure_time = $urandom;
            end
            soft_trig   = ($urandom_range(0, 99) < 4);
            reg_cnt_clr = ($urandom_range(0, 199) < 1);
            if ($urandom_range(0, 99) < 5) ext_trig_in = ~ext_trig_in;
            tick();
        end
        reg_trig_mode = 2'd0;
        ext_trig_in   = 1'b0;
        repeat (200) tick();

        // reset in the middle of a pulse
        reg_trig_mode    = 2'd3;
        reg_trig_delay   = 32'd0;
        reg_frame_period = 32'd30;
        reg_chan_mask    = 2'd1;
        soft_trig = 1'b1; tick();
        tick();
        soft_trig = 1'b1; tick();
        tick();
        check("pulse_before_reset", longint'(trigger_out), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        sb.delete();
        idle_from     = 0;
        alt           = 0;
        frames_m      = 0;
        drops_m       = 0;
        reg_trig_mode = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        reg_trig_mode = 2'd3;
        soft_trig = 1'b1; tick();
        repeat (3) tick();
        soft_trig = 1'b1; tick();
        repeat (40) tick();
        reg_chan_mask = 2'd0;
        soft_trig = 1'b1; tick();
        repeat (10) tick();
        reg_chan_mask = 2'd3;
        soft_trig = 1'b1; tick();
        repeat (40) tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
